// File: rtl/riffa_tx_arbiter_pkg.sv
// Shared definitions for the RIFFA TX arbiter: channel signal widths, FSM
// state encoding and a constant-foldable ceil(log2) helper.
package riffa_tx_arbiter_pkg;

   localparam int SIG_CHNL_LENGTH_W = 32;
   localparam int SIG_CHNL_OFFSET_W = 31;

   typedef logic [1:0] arb_state_t;

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_WAIT_ACK = 2'd1;
   localparam logic [1:0] ST_DATA     = 2'd2;
   localparam logic [1:0] ST_FIN      = 2'd3;

   function automatic int clog2(input int value);
      int res;
      res = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) res = i + 1;
      end
      return res;
   endfunction

endpackage

// File: rtl/riffa_tx_arbiter_if.sv
// Requester-side and endpoint-side signal bundle of the RIFFA TX arbiter.
// master = arbiter, slave = requesters plus the riffa channel endpoint.
interface riffa_tx_arbiter_if #(
   parameter int C_NUM_REQ        = 4,
   parameter int C_PCI_DATA_WIDTH = 128,
   parameter int C_LEN_W          = 32,
   parameter int C_OFF_W          = 31
);
   logic [C_NUM_REQ-1:0]                  REQ;
   logic [C_NUM_REQ*C_LEN_W-1:0]          REQ_LEN;
   logic [C_NUM_REQ*C_OFF_W-1:0]          REQ_OFF;
   logic [C_NUM_REQ-1:0]                  REQ_LAST;
   logic [C_NUM_REQ-1:0]                  GNT;
   logic [C_NUM_REQ-1:0]                  DONE;
   logic [C_NUM_REQ*C_PCI_DATA_WIDTH-1:0] REQ_DATA;
   logic [C_NUM_REQ-1:0]                  REQ_DATA_VALID;
   logic [C_NUM_REQ-1:0]                  REQ_DATA_REN;
   logic                                  CHNL_TX_CLK;
   logic                                  CHNL_TX;
   logic                                  CHNL_TX_ACK;
   logic                                  CHNL_TX_LAST;
   logic [C_LEN_W-1:0]                    CHNL_TX_LEN;
   logic [C_OFF_W-1:0]                    CHNL_TX_OFF;
   logic [C_PCI_DATA_WIDTH-1:0]           CHNL_TX_DATA;
   logic                                  CHNL_TX_DATA_VALID;
   logic                                  CHNL_TX_DATA_REN;

   // A data beat moves on every rising CLK where the source's VALID and the
   // sink's REN are both high; VALID never waits for REN, and a source holds
   // its data unchanged until that beat is taken.
   modport master (
      input  REQ, REQ_LEN, REQ_OFF, REQ_LAST, REQ_DATA, REQ_DATA_VALID,
      input  CHNL_TX_ACK, CHNL_TX_DATA_REN,
      output GNT, DONE, REQ_DATA_REN,
      output CHNL_TX_CLK, CHNL_TX, CHNL_TX_LAST, CHNL_TX_LEN, CHNL_TX_OFF,
      output CHNL_TX_DATA, CHNL_TX_DATA_VALID
   );

   modport slave (
      output REQ, REQ_LEN, REQ_OFF, REQ_LAST, REQ_DATA, REQ_DATA_VALID,
      output CHNL_TX_ACK, CHNL_TX_DATA_REN,
      input  GNT, DONE, REQ_DATA_REN,
      input  CHNL_TX_CLK, CHNL_TX, CHNL_TX_LAST, CHNL_TX_LEN, CHNL_TX_OFF,
      input  CHNL_TX_DATA, CHNL_TX_DATA_VALID
   );

endinterface

// File: rtl/riffa_tx_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request strictly after ptr,
// wrapping, returned as one-hot and as an index. Shared with the RX side.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int PW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [PW-1:0] idx,
   output logic          any
);

   always_comb begin
      int j;
      gnt = '0;
      idx = '0;
      any = 1'b0;
      j   = 0;
      for (int i = 1; i <= N; i++) begin
         j = int'(ptr) + i;
         if (j >= N) j = j - N;
         if (!any && req[j]) begin
            any    = 1'b1;
            gnt[j] = 1'b1;
            idx    = PW'(j);
         end
      end
   end

endmodule

// File: rtl/riffa_tx_arbiter.sv
// Round-robin share of one RIFFA TX channel among C_NUM_REQ requesters.
// Define RIFFA_TX_ARB_STATS_EN to add per-requester beat counters (STAT_BEATS).
module riffa_tx_arbiter
   import riffa_tx_arbiter_pkg::*;
#(
   parameter int C_NUM_REQ        = 4,
   parameter int C_PCI_DATA_WIDTH = 128,
   parameter int C_LEN_W          = SIG_CHNL_LENGTH_W,
   parameter int C_OFF_W          = SIG_CHNL_OFFSET_W
) (
   input  logic                   CLK,
   input  logic                   RST_N,
   riffa_tx_arbiter_if.master     bus,
   output logic [1:0]             DBG_STATE,
   output logic [C_LEN_W-1:0]     DBG_BEATS
`ifdef RIFFA_TX_ARB_STATS_EN
   ,
   output logic [C_NUM_REQ*32-1:0] STAT_BEATS
`endif
);

   localparam int WPB     = C_PCI_DATA_WIDTH / 32;
   localparam int LOG_WPB = clog2(WPB);
   localparam int PW      = (C_NUM_REQ > 1) ? clog2(C_NUM_REQ) : 1;
   localparam logic [C_LEN_W-1:0] ONE_BEAT = C_LEN_W'(1);

   arb_state_t            state;
   logic [PW-1:0]         ptr;
   logic [PW-1:0]         win;
   logic [C_LEN_W-1:0]    beats_left;
   logic [C_NUM_REQ-1:0]  gnt_q;
   logic [C_NUM_REQ-1:0]  done_q;
   logic                  tx_q;
   logic                  last_q;
   logic [C_LEN_W-1:0]    len_q;
   logic [C_OFF_W-1:0]    off_q;

   logic [C_NUM_REQ-1:0]  arb_gnt;
   logic [PW-1:0]         arb_idx;
   logic                  arb_any;
   logic [C_LEN_W-1:0]    sel_len;
   logic [C_OFF_W-1:0]    sel_off;
   logic [C_LEN_W:0]      len_sum;
   logic [C_LEN_W:0]      len_shift;
   logic [C_LEN_W-1:0]    beat_load;
   logic                  unused_len_msb;
   logic                  hs;
   logic                  finish;
   logic [C_NUM_REQ-1:0]  ren;

   rr_arbiter #(.N(C_NUM_REQ), .PW(PW)) u_rr (
      .req (bus.REQ),
      .ptr (ptr),
      .gnt (arb_gnt),
      .idx (arb_idx),
      .any (arb_any)
   );

   assign sel_len = bus.REQ_LEN[arb_idx*C_LEN_W +: C_LEN_W];
   assign sel_off = bus.REQ_OFF[arb_idx*C_OFF_W +: C_OFF_W];

   // One spare bit keeps LEN=all-ones from wrapping before the shift.
   assign len_sum        = {1'b0, sel_len} + (C_LEN_W+1)'(WPB - 1);
   assign len_shift      = len_sum >> LOG_WPB;
   assign beat_load      = len_shift[C_LEN_W-1:0];
   assign unused_len_msb = len_shift[C_LEN_W];

   assign hs     = (state == ST_DATA) && bus.REQ_DATA_VALID[win] && bus.CHNL_TX_DATA_REN;
   assign finish = ((state == ST_WAIT_ACK) && bus.CHNL_TX_ACK && (beats_left == '0)) ||
                   (hs && (beats_left == ONE_BEAT));

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state      <= ST_IDLE;
         ptr        <= PW'(C_NUM_REQ - 1);
         win        <= '0;
         beats_left <= '0;
         gnt_q      <= '0;
         done_q     <= '0;
         tx_q       <= 1'b0;
         last_q     <= 1'b0;
         len_q      <= '0;
         off_q      <= '0;
      end else begin
         done_q <= '0;
         case (state)
            ST_IDLE: begin
               if (arb_any) begin
                  state      <= ST_WAIT_ACK;
                  gnt_q      <= arb_gnt;
                  ptr        <= arb_idx;
                  win        <= arb_idx;
                  len_q      <= sel_len;
                  off_q      <= sel_off;
                  last_q     <= bus.REQ_LAST[arb_idx];
                  beats_left <= beat_load;
                  tx_q       <= 1'b1;
               end
            end
            ST_WAIT_ACK: begin
               if (bus.CHNL_TX_ACK) state <= ST_DATA;
            end
            ST_DATA: begin
               if (hs) beats_left <= beats_left - ONE_BEAT;
            end
            ST_FIN:  state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
         // FIN drops the channel and grant for one cycle while DONE pulses.
         if (finish) begin
            state  <= ST_FIN;
            tx_q   <= 1'b0;
            gnt_q  <= '0;
            done_q <= gnt_q;
         end
      end
   end

   always_comb begin
      ren = '0;
      if (state == ST_DATA) ren[win] = bus.CHNL_TX_DATA_REN;
   end

   assign bus.CHNL_TX_CLK        = CLK;
   assign bus.CHNL_TX            = tx_q;
   assign bus.CHNL_TX_LAST       = last_q;
   assign bus.CHNL_TX_LEN        = len_q;
   assign bus.CHNL_TX_OFF        = off_q;
   assign bus.GNT                = gnt_q;
   assign bus.DONE               = done_q;
   assign bus.REQ_DATA_REN       = ren;
   assign bus.CHNL_TX_DATA       = bus.REQ_DATA[win*C_PCI_DATA_WIDTH +: C_PCI_DATA_WIDTH];
   assign bus.CHNL_TX_DATA_VALID = (state == ST_DATA) && bus.REQ_DATA_VALID[win];

   assign DBG_STATE = state;
   assign DBG_BEATS = beats_left;

`ifdef RIFFA_TX_ARB_STATS_EN
   for (genvar r = 0; r < C_NUM_REQ; r++) begin : g_stat
      logic [31:0] cnt;
      always_ff @(posedge CLK or negedge RST_N) begin
         if (!RST_N) cnt <= '0;
         else if (hs && (win == PW'(r)) && (cnt != '1)) cnt <= cnt + 32'd1;
      end
      assign STAT_BEATS[r*32 +: 32] = cnt;
   end
`endif

endmodule

// File: tb/tb_riffa_tx_arbiter.sv
// Directed bench for riffa_tx_arbiter: table of arbitration/transfer vectors
// plus hand-written reset and maximum-length sequences.
module tb_riffa_tx_arbiter;
   import riffa_tx_arbiter_pkg::*;

   localparam int NR = 4;
   localparam int W  = 128;
   localparam int LW = 32;
   localparam int OW = 31;

   // clock / reset
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   riffa_tx_arbiter_if #(.C_NUM_REQ(NR), .C_PCI_DATA_WIDTH(W), .C_LEN_W(LW), .C_OFF_W(OW)) bus ();

   logic [1:0]    dbg_state;
   logic [LW-1:0] dbg_beats;
`ifdef RIFFA_TX_ARB_STATS_EN
   logic [NR*32-1:0] stat_beats;
`endif

   riffa_tx_arbiter #(.C_NUM_REQ(NR), .C_PCI_DATA_WIDTH(W), .C_LEN_W(LW), .C_OFF_W(OW)) dut (
      .CLK       (clk),
      .RST_N     (rst_n),
      .bus       (bus),
      .DBG_STATE (dbg_state),
      .DBG_BEATS (dbg_beats)
`ifdef RIFFA_TX_ARB_STATS_EN
      ,
      .STAT_BEATS(stat_beats)
`endif
   );

   // scoreboard state
   logic [W-1:0]  exp_q[$];
   int            checks = 0;
   int            errors = 0;
   int            src_seq[NR];
   int            exp_stat[NR];
   int            ch_beats, last_hs, step_cnt, cyc, vm, rm;
   logic [NR-1:0] ren_or, ren_foreign;
   logic          done_seen;

   typedef struct {
      logic [NR-1:0] req;
      logic [LW-1:0] len;
      int            exp_w;
      int            exp_beats;
      int            vmode;
      int            rmode;
      int            ack_dly;
   } vec_t;
   vec_t tbl[12];

   function automatic logic [W-1:0] data_word(input int r, input int s);
      logic [W-1:0] d;
      for (int w = 0; w < W/32; w++) d[w*32 +: 32] = {8'(r + 1), 16'(s), 8'(w)};
      return d;
   endfunction

   function automatic logic [OW-1:0] req_off(input int r);
      return OW'(r * 4096 + 85);
   endfunction

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // driver tasks
   task automatic apply_src();
      for (int r = 0; r < NR; r++) bus.REQ_DATA[r*W +: W] = data_word(r, src_seq[r]);
      case (vm)
         0:       bus.REQ_DATA_VALID = '1;
         1:       bus.REQ_DATA_VALID = (cyc % 3 == 2) ? '0 : '1;
         default: bus.REQ_DATA_VALID = '0;
      endcase
      bus.CHNL_TX_DATA_REN = (rm == 0) ? 1'b1 : (cyc % 2 == 0);
   endtask

   task automatic step();
      logic [NR-1:0] adv;
      @(negedge clk);
      if (bus.CHNL_TX_DATA_VALID && bus.CHNL_TX_DATA_REN) begin
         ch_beats++;
         last_hs = step_cnt;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_beat: got data %0h expected no beat", bus.CHNL_TX_DATA);
         end else begin
            check("tx_data", bus.CHNL_TX_DATA, exp_q.pop_front());
         end
      end
      adv          = bus.REQ_DATA_REN & bus.REQ_DATA_VALID;
      ren_or      |= bus.REQ_DATA_REN;
      ren_foreign |= bus.REQ_DATA_REN & ~bus.GNT;
      done_seen   |= |bus.DONE;
      @(posedge clk);
      #1;
      step_cnt++;
      cyc++;
      for (int r = 0; r < NR; r++) if (adv[r]) src_seq[r]++;
      apply_src();
   endtask

   task automatic do_xfer(input string nm, input logic [NR-1:0] req, input logic [LW-1:0] len,
                          input int exp_w, input int exp_beats, input int vmode, input int rmode,
                          input int ack_dly, input bit drop, output int gap);
      int            budget;
      logic [NR-1:0] oh;
      oh        = '0;
      oh[exp_w] = 1'b1;
      bus.REQ   = req;
      for (int r = 0; r < NR; r++) bus.REQ_LEN[r*LW +: LW] = len;
      for (int b = 0; b < exp_beats; b++) exp_q.push_back(data_word(exp_w, src_seq[exp_w] + b));
      ch_beats    = 0;
      ren_or      = '0;
      ren_foreign = '0;
      vm          = vmode;
      rm          = rmode;
      apply_src();
      gap    = 0;
      budget = 0;
      while (!bus.CHNL_TX && budget < 20) begin
         step();
         gap++;
         budget++;
      end
      check({nm, "_tx_rise"}, bus.CHNL_TX, 1);
      check({nm, "_gnt"}, bus.GNT, oh);
      check({nm, "_len"}, bus.CHNL_TX_LEN, len);
      check({nm, "_off"}, bus.CHNL_TX_OFF, req_off(exp_w));
      check({nm, "_last"}, bus.CHNL_TX_LAST, exp_w % 2);
      check({nm, "_beat_load"}, dbg_beats, exp_beats);
      if (drop) bus.REQ = '0;
      repeat (ack_dly) step();
      check({nm, "_wait_ack"}, dbg_state, ST_WAIT_ACK);
      bus.CHNL_TX_ACK = 1'b1;
      step();
      bus.CHNL_TX_ACK = 1'b0;
      budget = 0;
      while (bus.DONE == '0 && budget < 200) begin
         step();
         budget++;
      end
      check({nm, "_done"}, bus.DONE, oh);
      check({nm, "_tx_fall"}, bus.CHNL_TX, 0);
      check({nm, "_gnt_clear"}, bus.GNT, 0);
      check({nm, "_beats"}, ch_beats, exp_beats);
      check({nm, "_q_empty"}, exp_q.size(), 0);
      if (exp_beats > 0) check({nm, "_done_lat"}, step_cnt - last_hs, 1);
      else               check({nm, "_no_ren"}, ren_or, 0);
      check({nm, "_ren_foreign"}, ren_foreign, 0);
      exp_stat[exp_w] += exp_beats;
      vm = 0;
      rm = 0;
   endtask

   task automatic reset_now_check(input string nm);
      #2;
      rst_n = 1'b0;
      #1;
      check({nm, "_state"}, dbg_state, ST_IDLE);
      check({nm, "_tx"}, bus.CHNL_TX, 0);
      check({nm, "_gnt"}, bus.GNT, 0);
      check({nm, "_done"}, bus.DONE, 0);
      check({nm, "_valid"}, bus.CHNL_TX_DATA_VALID, 0);
      check({nm, "_ren"}, bus.REQ_DATA_REN, 0);
      check({nm, "_len"}, bus.CHNL_TX_LEN, 0);
      check({nm, "_off"}, bus.CHNL_TX_OFF, 0);
      check({nm, "_last"}, bus.CHNL_TX_LAST, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached before summary");
      $fatal(1);
   end

   initial begin
      int budget;
      int gap;
      tbl[0]  = '{4'b1111, 32'd4,  0, 1, 0, 0, 0};
      tbl[1]  = '{4'b1111, 32'd4,  1, 1, 0, 0, 1};
      tbl[2]  = '{4'b1111, 32'd4,  2, 1, 0, 0, 0};
      tbl[3]  = '{4'b1111, 32'd4,  3, 1, 0, 0, 2};
      tbl[4]  = '{4'b1111, 32'd4,  0, 1, 0, 0, 0};
      tbl[5]  = '{4'b1010, 32'd9,  1, 3, 1, 0, 0};
      tbl[6]  = '{4'b1010, 32'd9,  3, 3, 0, 1, 0};
      tbl[7]  = '{4'b0101, 32'd1,  0, 1, 0, 0, 1};
      tbl[8]  = '{4'b0100, 32'd16, 2, 4, 1, 1, 0};
      tbl[9]  = '{4'b1001, 32'd7,  3, 2, 0, 0, 0};
      tbl[10] = '{4'b0110, 32'd0,  1, 0, 0, 0, 2};
      tbl[11] = '{4'b0010, 32'd5,  1, 2, 1, 1, 0};

      ch_beats = 0; last_hs = 0; step_cnt = 0; cyc = 0; vm = 0; rm = 0;
      ren_or = '0; ren_foreign = '0; done_seen = 1'b0;
      for (int r = 0; r < NR; r++) begin
         src_seq[r]  = 0;
         exp_stat[r] = 0;
         bus.REQ_OFF[r*OW +: OW] = req_off(r);
         bus.REQ_LAST[r]         = 1'(r % 2);
      end
      bus.REQ         = '0;
      bus.REQ_LEN     = '0;
      bus.CHNL_TX_ACK = 1'b0;
      apply_src();

      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      check("rst_state", dbg_state, ST_IDLE);
      check("rst_tx", bus.CHNL_TX, 0);
      check("rst_gnt", bus.GNT, 0);
      check("rst_done", bus.DONE, 0);
      check("rst_len", bus.CHNL_TX_LEN, 0);
      check("rst_off", bus.CHNL_TX_OFF, 0);
      check("rst_last", bus.CHNL_TX_LAST, 0);
      check("rst_valid", bus.CHNL_TX_DATA_VALID, 0);

      // Round-robin order, back-to-back spacing and varied lengths/stalls.
      for (int i = 0; i < 12; i++) begin
         do_xfer($sformatf("vec%0d", i), tbl[i].req, tbl[i].len, tbl[i].exp_w, tbl[i].exp_beats,
                 tbl[i].vmode, tbl[i].rmode, tbl[i].ack_dly, 1'b0, gap);
         check($sformatf("vec%0d_tx_gap", i), gap >= 1, 1);
      end
      bus.REQ = '0;
      step();
      step();
`ifdef RIFFA_TX_ARB_STATS_EN
      for (int r = 0; r < NR; r++) check($sformatf("stat_tbl%0d", r), stat_beats[r*32 +: 32], exp_stat[r]);
`endif

      // Maximum length: beat count must not wrap, then abort by reset.
      bus.REQ = 4'b0100;
      for (int r = 0; r < NR; r++) bus.REQ_LEN[r*LW +: LW] = 32'hFFFF_FFFF;
      budget = 0;
      while (!bus.CHNL_TX && budget < 20) begin
         step();
         budget++;
      end
      check("max_tx_rise", bus.CHNL_TX, 1);
      check("max_len", bus.CHNL_TX_LEN, 32'hFFFF_FFFF);
      check("max_beat_load", dbg_beats, 32'h4000_0000);
      bus.REQ = '0;
      reset_now_check("max_rst");
      repeat (2) step();
      #1;
      rst_n = 1'b1;
      for (int r = 0; r < NR; r++) exp_stat[r] = 0;

      // Reset during DATA after one of three beats: immediate abort, no DONE.
      bus.REQ = 4'b0100;
      for (int r = 0; r < NR; r++) bus.REQ_LEN[r*LW +: LW] = 32'd12;
      for (int b = 0; b < 3; b++) exp_q.push_back(data_word(2, src_seq[2] + b));
      ch_beats  = 0;
      done_seen = 1'b0;
      budget    = 0;
      while (!bus.CHNL_TX && budget < 20) begin
         step();
         budget++;
      end
      check("mid_beat_load", dbg_beats, 3);
      bus.REQ = '0;
      bus.CHNL_TX_ACK = 1'b1;
      step();
      bus.CHNL_TX_ACK = 1'b0;
      budget = 0;
      while (ch_beats < 1 && budget < 20) begin
         step();
         budget++;
      end
      vm = 2;
      bus.REQ_DATA_VALID = '0;
      check("mid_one_beat", ch_beats, 1);
      check("mid_state_data", dbg_state, ST_DATA);
      reset_now_check("mid_rst");
      repeat (3) step();
      check("mid_no_done", done_seen, 0);
      exp_q.delete();
      vm = 0;
      apply_src();
      rst_n = 1'b1;

      // After reset requester 0 wins first; ACK three cycles after CHNL_TX.
      do_xfer("post_rst", 4'b1111, 32'd8, 0, 2, 0, 0, 3, 1'b1, gap);
      check("post_rst_req_to_tx", gap, 1);
`ifdef RIFFA_TX_ARB_STATS_EN
      for (int r = 0; r < NR; r++) check($sformatf("stat_post%0d", r), stat_beats[r*32 +: 32], exp_stat[r]);
`endif
      step();
      check("final_idle", dbg_state, ST_IDLE);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/riffa_tx_arbiter.md
Name: riffa_tx_arbiter

Overview:
Shares one RIFFA TX channel (CHNL_TX_* endpoint-facing side) among C_NUM_REQ user requesters using round-robin arbitration. Latches the winner's length, offset and last flag. Drives the CHNL_TX/ACK handshake and muxes the winner's data stream onto CHNL_TX_DATA, counting beats until the transfer completes. Sits between user cores (e.g. chnl_tester instances) and one riffa_pango channel.

Parameters:
C_NUM_REQ, 4, number of requesters (1..16)
C_PCI_DATA_WIDTH, 128, data width in bits (32/64/128)
C_LEN_W, 32, length width in 32-bit words (matches SIG_CHNL_LENGTH_W)
C_OFF_W, 31, offset width (matches SIG_CHNL_OFFSET_W)

Ports:
CLK  in  1  single clock for all logic
RST_N  in  1  asynchronous, active-low reset
REQ  in  C_NUM_REQ  per-requester transfer request, level
REQ_LEN  in  C_NUM_REQ*C_LEN_W  packed lengths in words
REQ_OFF  in  C_NUM_REQ*C_OFF_W  packed offsets
REQ_LAST  in  C_NUM_REQ  packed last flags
GNT  out  C_NUM_REQ  one-hot grant, held for the whole transaction
DONE  out  C_NUM_REQ  one-cycle completion pulse to the granted requester
REQ_DATA  in  C_NUM_REQ*C_PCI_DATA_WIDTH  packed data
REQ_DATA_VALID  in  C_NUM_REQ  per-requester data valid
REQ_DATA_REN  out  C_NUM_REQ  per-requester data accept
CHNL_TX_CLK  out  1  tied to CLK
CHNL_TX  out  1  transaction active
CHNL_TX_ACK  in  1  endpoint acknowledge
CHNL_TX_LAST  out  1  latched last flag
CHNL_TX_LEN  out  C_LEN_W  latched length
CHNL_TX_OFF  out  C_OFF_W  latched offset
CHNL_TX_DATA  out  C_PCI_DATA_WIDTH  muxed data from the granted requester
CHNL_TX_DATA_VALID  out  1  muxed valid
CHNL_TX_DATA_REN  in  1  endpoint data accept

Behaviour:
- Reset (RST_N low, asynchronous): state=IDLE; GNT, DONE, CHNL_TX, CHNL_TX_LAST, LEN, OFF = 0; RR pointer = C_NUM_REQ-1, so requester 0 wins first. Reset mid-transfer aborts immediately with no DONE.
- States: IDLE, WAIT_ACK, DATA, FIN.
- IDLE: any REQ set -> next edge:
  - pick the first set bit searching upward from pointer+1 (wrapping);
  - set GNT one-hot and pointer=winner;
  - latch LEN/OFF/LAST;
  - load beat count = ceil(LEN/(C_PCI_DATA_WIDTH/32)), computed as (LEN+WPB-1)>>log2(WPB) with C_LEN_W+1 bits to avoid overflow at LEN=all-ones;
  - assert CHNL_TX; go to WAIT_ACK.
- WAIT_ACK: CHNL_TX_ACK=1 -> DATA, or -> FIN if beat count==0. Wait indefinitely otherwise.
- DATA:
  - CHNL_TX_DATA/VALID = winner's data/valid (combinational mux); REQ_DATA_REN[winner] = CHNL_TX_DATA_REN; all other REN = 0.
  - VALID and REN both high counts one beat.
  - The handshake on the final beat -> FIN at the next edge.
  - VALID is forced 0 outside DATA.
  - Partial final beat: unused upper words pass through unchanged.
- FIN (one cycle): CHNL_TX=0, GNT=0, DONE[winner]=1 -> IDLE. This guarantees CHNL_TX is low for at least one cycle between transactions. Minimum spacing: REQ seen -> CHNL_TX high 1 cycle later.
- REQ is ignored while not IDLE. Dropping REQ before the grant withdraws the request. The granted requester may keep REQ high for a back-to-back request; RR then favours the others first.
- LEN/OFF/LAST stay stable while CHNL_TX is high.
- C_NUM_REQ=1: arbitration degenerates to a fixed grant.

Optional Feature:
RIFFA_TX_ARB_STATS_EN: adds output STAT_BEATS[C_NUM_REQ*32], per-requester saturating counters of beats transferred, incremented on each DATA handshake and cleared by reset. Without the macro the port and counters are absent.

Decomposition:
- Shared package/header (riffa.vh style): state encoding localparams, SIG_CHNL_LENGTH_W/OFFSET_W, a function clog2.
- One sub-module: rr_arbiter (REQ vector, pointer -> one-hot winner, any), purely combinational, reusable for the RX side.

Test Plan:
- Single requester 0, LEN=8, W=128, ACK after 3 cycles, REN held high:
  - CHNL_TX rises 1 cycle after REQ;
  - 2 beats transfer;
  - CHNL_TX falls and DONE[0] pulses 1 cycle after the 2nd beat.
- All 4 REQ held high, LEN=4 each: grant order 0,1,2,3,0; CHNL_TX low for 1 cycle between transactions.
- LEN=5, W=128, REN toggling 1/0 and VALID with gaps: exactly 2 beats counted, only on VALID&REN; the stalled beat's data is held and not lost.
- LEN=0: ACK -> FIN with no data beats; DONE pulses; REQ_DATA_REN never asserts.
- RST_N low during DATA after 1 of 3 beats: all outputs 0 immediately, no DONE; after release, requester 0 wins first again.
- LEN=32'hFFFFFFFF: latched beat count is 0x40000000 (no wrap); with STATS_EN, after a LEN=8 transfer STAT_BEATS[0]=2.
